logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR/pass-A) between NREQ requesters, e.g. EX-stage and a branch/compare helper.
- Round-robin arbitration. Per-requester valid/ready request handshake.
- One-entry registered result stage with valid/ready backpressure. Each result is tagged with the id of the requester that issued it.
- Instantiates the team's existing Logic unit combinationally between the grant mux and the result register.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of requester id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  bit i: requester i presents an operation.
- req_ready  output  NREQ  bit i: requester i's operation is accepted this cycle; at most one bit high.
- req_a  input  32*NREQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  input  32*NREQ  operand B, same packing.
- req_func  input  4*NREQ  function code; requester i occupies bits [4i+3:4i].
- res_valid  output  1  result register holds an undelivered result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  32  logic result.
- res_id  output  IDW  index of the requester that produced res_data.
- busy_cnt  output  8  saturating count of cycles with at least one req_valid high and no grant (stall statistic).

Behaviour:
- **Function encoding**, decoded on func[3:1]; func[0] is ignored:
  - 000 -> NOR(A,B)
  - 011 -> XOR
  - 100 -> AND
  - 111 -> OR
  - 001, 010, 101, 110 -> A (pass).
- **Reset:** synchronous on clk when rst=1.
  - res_valid=0, res_data=0, res_id=0, busy_cnt=0.
  - Round-robin pointer rr_ptr=0. req_ready is all-zero during reset.
- **Slot free:** slot_free = !res_valid || res_ready (combinational).
- **Grant:**
  - When slot_free, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ..., rr_ptr-1.
  - req_ready is a combinational one-hot of the grant; it is zero when !slot_free or no valid request.
  - req_ready never depends on req_ready; it depends on req_valid, res_valid, res_ready and state only.
- **Transfer:** requester i's operation transfers when req_valid[i] && req_ready[i].
  - On the next edge: res_data <= Logic(a_i, b_i, func_i), res_id <= i, res_valid <= 1, rr_ptr <= (i+1) mod NREQ.
- **Latency:** exactly 1 cycle from request transfer to res_valid. Throughput is 1 op/cycle while res_ready=1.
- **Drain with no new grant:** res_valid && res_ready with no new transfer -> res_valid <= 0. res_data and res_id hold their last values.
- **Simultaneous drain and accept:** res_ready=1 and a new transfer in the same cycle -> res_valid stays 1 and data is replaced. No bubble.
- **Backpressure:** res_valid && !res_ready -> all req_ready=0. res_data and res_id are held stable. rr_ptr does not change.
- **rr_ptr wrap:** advances only on a grant; wraps from NREQ-1 to 0.
- **Fairness:** a requester holding req_valid continuously is granted within NREQ grants.
- **Request withdrawal:** requesters must hold valid and operands until ready. A withdrawn request (valid dropped without ready) is simply not granted; no error is raised.
- **busy_cnt:** increments when |req_valid && no grant. It saturates at 255 and never wraps.
- **Reset mid-operation:** any pending result is discarded (res_valid=0 the cycle after rst), and rr_ptr returns to 0.

Test Plan:
- **Reset:** hold rst=1 for 2 cycles with req_valid=2'b11 -> req_ready=00, res_valid=0, busy_cnt=0. After release, req_ready=01 (rr_ptr=0).
- **Function decode:** A=0xF0F0_1234, B=0x0FF0_FFFF via requester 0, res_ready=1.
  - Expected results next cycle: func=0x0 -> 0x000F_0000; 0x6 -> 0xFF00_EDCB; 0x8 -> 0x00F0_1234; 0xE -> 0xFFF0_FFFF; 0x2 -> 0xF0F0_1234.
  - res_id=0 in every case.
- **Round-robin:** both requesters valid continuously, res_ready=1.
  - Grants alternate 0,1,0,1 and res_id sequence is 0,1,0,1.
  - No cycle has res_valid=0 after the first result.
- **Backpressure:** one result pending, res_ready=0 for 3 cycles, req_valid=11.
  - req_ready=00 and res_data/res_id stable for those 3 cycles; busy_cnt increments by 3.
  - On res_ready=1, the next grant goes to the requester after the last grantee.
- **Drain+accept in one cycle:** res_valid=1, res_ready=1, req_valid[1]=1 -> res_valid remains 1 next cycle, res_id=1, new data, no bubble.
- **Reset mid-stream and saturation:**
  - Assert rst while res_valid=1 -> res_valid=0 next cycle, rr_ptr=0.
  - Separately hold a 300-cycle stall -> busy_cnt=255.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit between NREQ requesters,
// with a one-entry registered result stage (valid/ready) tagged by requester id.
module logic_unit_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]    req_func,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [IDW-1:0]       res_id,
    output logic [7:0]           busy_cnt
);

    localparam int unsigned DW  = 32;
    localparam int unsigned FW  = 4;
    localparam int unsigned CW  = 8;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_data_q,  res_data_d;
    logic [IDW-1:0]  res_id_q,    res_id_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [CW-1:0]   busy_cnt_q,  busy_cnt_d;

    logic            slot_free;
    logic            gnt_found;
    logic            grant;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [2:0]      op_sel;
    logic [DW-1:0]   op_res;

    // Bitwise logic unit; only func[3:1] selects the operation.
    function automatic logic [DW-1:0] logic_unit(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic [2:0]    sel);
        logic [DW-1:0] r;
        unique case (sel)
            3'b000:  r = ~(a | b);
            3'b011:  r = a ^ b;
            3'b100:  r = a & b;
            3'b111:  r = a | b;
            default: r = a;
        endcase
        return r;
    endfunction

    // Round-robin search starting at rr_ptr; grant only when the result slot can take it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign slot_free = !res_valid_q || res_ready;
    assign grant     = !rst && slot_free && gnt_found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign op_a   = req_a[32'(gnt_idx)*DW +: DW];
    assign op_b   = req_b[32'(gnt_idx)*DW +: DW];
    assign op_sel = req_func[32'(gnt_idx)*FW + 1 +: 3];
    assign op_res = logic_unit(op_a, op_b, op_sel);

    // Next state of the result stage, pointer and stall counter.
    always_comb begin
        res_valid_d = res_valid_q && !res_ready;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        busy_cnt_d  = busy_cnt_q;
        if (grant) begin
            res_valid_d = 1'b1;
            res_data_d  = op_res;
            res_id_d    = gnt_idx;
            rr_ptr_d    = IDW'((32'(gnt_idx) + 32'd1) % NREQ);
        end
        if ((|req_valid) && !grant && (busy_cnt_q != CNT_MAX)) begin
            busy_cnt_d = busy_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
            busy_cnt_q  <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized bench for logic_unit_arbiter against a transaction-level reference model.
module tb_logic_unit_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [4*NREQ-1:0]    req_func;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_data;
    logic [IDW-1:0]       res_id;
    logic [7:0]           busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_ptr;
    int          m_busy;

    logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_func  (req_func),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
        int code;
        code = int'(f) / 2;
        case (code)
            0:       return ~(a | b);
            3:       return a ^ b;
            4:       return a & b;
            7:       return a | b;
            default: return a;
        endcase
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model across the next edge.
    task automatic cycle();
        int          g;
        int          idx;
        logic [31:0] exp_rdy;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        @(negedge clk);
        g = -1;
        if (!rst && (!m_valid || res_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        check("req_ready", 32'(req_ready), exp_rdy);
        check("res_valid", 32'(res_valid), 32'(m_valid));
        check("res_data",  res_data, m_data);
        check("res_id",    32'(res_id), 32'(m_id));
        check("busy_cnt",  32'(busy_cnt), 32'(m_busy));
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_busy = 0;
        end else begin
            if (|req_valid && g < 0 && m_busy < 255) m_busy++;
            if (g >= 0) begin
                a = req_a[g*32 +: 32];
                b = req_b[g*32 +: 32];
                f = req_func[g*4 +: 4];
                m_valid = 1'b1;
                m_data  = ref_op(a, b, f);
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  dec_func [5] = '{4'h0, 4'h6, 4'h8, 4'hE, 4'h2};
    logic [31:0] dec_exp  [5] = '{32'h000F_0000, 32'hFF00_EDCB, 32'h00F0_1234,
                                  32'hFFF0_FFFF, 32'hF0F0_1234};

    initial begin
        logic [31:0] held_data;
        int          prev_id;
        rst = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
        req_a = '0; req_b = '0; req_func = '0;
        m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_busy = 0;
        @(posedge clk); #1;
        cycle();
        // Release reset: requester 0 wins first
        rst = 1'b0; req_valid = 2'b11;
        cycle();

        // Function decode via requester 0
        rst = 1'b1; cycle(); rst = 1'b0;
        res_ready = 1'b1;
        req_a[31:0] = 32'hF0F0_1234;
        req_b[31:0] = 32'h0FF0_FFFF;
        for (int i = 0; i < 5; i++) begin
            req_valid = 2'b01;
            req_func[3:0] = dec_func[i];
            cycle();
            check("decode_data", res_data, dec_exp[i]);
            check("decode_id", 32'(res_id), 32'd0);
        end

        // Round-robin with continuous demand: ids alternate, no bubbles
        req_valid = 2'b11;
        req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
        cycle();
        prev_id = int'(res_id);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_valid", 32'(res_valid), 32'd1);
            check("rr_alt", 32'(res_id), 32'((prev_id + 1) % NREQ));
            prev_id = int'(res_id);
        end

        // Backpressure for 3 cycles
        res_ready = 1'b0;
        held_data = res_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold", res_data, held_data);
        end
        res_ready = 1'b1;
        cycle(); cycle();

        // Drain and accept in the same cycle from requester 1
        req_valid = 2'b10; req_func[7:4] = 4'h6;
        cycle();
        check("drain_accept_valid", 32'(res_valid), 32'd1);
        check("drain_accept_id", 32'(res_id), 32'd1);

        // Reset while a result is pending
        req_valid = 2'b00; res_ready = 1'b0;
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst_mid_valid", 32'(res_valid), 32'd0);
        req_valid = 2'b11; cycle();

        // Long stall saturates the counter
        for (int i = 0; i < 300; i++) cycle();
        check("busy_sat", 32'(busy_cnt), 32'd255);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            req_func  = 8'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
